psram_xfer_engine: RTL and testbench
====================================

// Module: psram_xfer_engine
// PURPOSE
//  Parametrised PSRAM transfer engine, successor to the fixed-OPI psram core.
//  Runs one CE#-framed command/address/wait/data transfer per request, over 1, 4 or 8 IO lanes
//  (SPI/QPI/OPI SDR), with a programmable SCK divider, read/write latency and CE# recovery.
//  Sits between the AXI4/APB4 front-end (request/response handshake) and the psram_if pads.
// PARAMETERS
//  DATA_BYTES  8   max data bytes per request (request data bus width = DATA_BYTES*8)
//  ADDR_WIDTH  32  address bits sent in ADDR phase; multiple of 8, sent MSB first
//  LEN_WIDTH   $clog2(DATA_BYTES+1)  width of req_len_i
// PORTS
//  clk_i          in   1            core clock
//  rst_n_i        in   1            reset, asynchronous, active-low
//  cfg_mode_i     in   2            0=SPI(1 lane) 1=QPI(4) 2=OPI(8) 3=reserved, treated as OPI
//  cfg_pscr_i     in   2            SCK half-period = pscr+1 clk cycles
//  cfg_recy_i     in   8            CE# high recovery clk cycles after response handshake
//  cfg_wlc_i      in   8            write dummy SCK cycles
//  cfg_rlc_i      in   8            read dummy SCK cycles
//  req_valid_i    in   1            request valid
//  req_ready_o    out  1            engine idle, request accepted on valid&ready
//  req_rdwr_i     in   1            1=read 0=write
//  req_cmd_i      in   8            command byte
//  req_addr_i     in   ADDR_WIDTH   transfer address
//  req_len_i      in   LEN_WIDTH    byte count, legal 1..DATA_BYTES
//  req_wdata_i    in   DATA_BYTES*8 write data; byte 0 = [7:0] sent first
//  rsp_valid_o    out  1            response valid, held until rsp_ready_i
//  rsp_ready_i    in   1            response accepted
//  rsp_rdata_o    out  DATA_BYTES*8 read data, byte 0 = first received; unused bytes 0
//  rsp_err_o      out  1            illegal request (len 0 or > DATA_BYTES)
//  busy_o         out  1            state != IDLE
//  psram_sck_o    out  1            PSRAM clock, idles low
//  psram_ce_o     out  1            chip enable, active-low
//  psram_io_en_o  out  8            per-lane output enable
//  psram_io_out_o out  8            lane output data
//  psram_io_in_i  in   8            lane input data
// BEHAVIOUR
//  - Reset: ce=1, sck=0, io_en=0, io_out=0, req_ready=1, rsp_valid=0, rdata=0, err=0, busy=0;
//    reset mid-transfer aborts immediately, CE# high, no response issued.
//  - All outputs registered. req_ready_o = (state==IDLE). cfg_* and req_* latched on accept.
//  - FSM: IDLE -> CMD -> ADDR -> WAIT -> DATA -> RESP -> RECY -> IDLE.
//    WAIT skipped when latched wlc/rlc = 0; RECY skipped when recy = 0 (RESP -> IDLE).
//    Illegal len: IDLE -> RESP directly, no CE#/SCK activity, err=1, rdata=0.
//  - Lanes L = 1/4/8. SCK cycles: CMD 8/L, ADDR ADDR_WIDTH/L, WAIT wlc|rlc, DATA len*8/L.
//    For SPI with ADDR_WIDTH=32 this is 8+32+wait+8*len; for OPI 1+4+wait+len.
//  - Timing: accept at edge T; CE# low from T+1; each SCK period = 2*(pscr+1) clks, low half first.
//    Outputs update when SCK falls (first bits valid at T+1); read data sampled on SCK rising clk.
//    After N total SCK periods CE# rises and rsp_valid_o asserts at T+1+2*(pscr+1)*N.
//  - Bit order MSB first; in SPI mode out on io[0], in on io[1]; QPI uses io[3:0].
//  - io_en = lane mask during CMD, ADDR and write DATA; 0 during WAIT, read DATA and idle.
//  - Write response: rsp_rdata_o=0, err=0.
//  - RESP holds rsp_valid/rdata/err stable until rsp_ready_i; handshake in same cycle as
//    assertion is legal. RECY then counts recy clks with CE# high; req_ready rises after.
//  - Simultaneous req_valid during non-IDLE: ignored (not accepted), no loss.
// TESTING
//  - SPI write len=1 pscr=0 wlc=0 ADDR=0x00001234 cmd=0x02 -> 48 SCK, rsp_valid at T+97, err=0.
//  - OPI read len=8 pscr=1 rlc=6 cmd=0xEB -> 19 SCK, rsp_valid at T+77, rdata = pad bytes in order.
//  - QPI write len=3 -> io_en=0x0F, 2+8+6 SCK, nibble sequence matches cmd/addr/data MSB first.
//  - len=0 and len=DATA_BYTES+1 -> CE# stays high, rsp_valid at T+1 with err=1.
//  - rsp_ready low 5 clks, recy=3 -> rsp held stable 5 clks, req_ready 3 clks after handshake.
//  - rst_n_i low mid-DATA -> CE# high, SCK low, io_en 0 asynchronously; no rsp after release.

Source files
------------

// File: rtl/psram_xfer_engine.sv
// PSRAM transfer engine: one CE#-framed cmd/addr/wait/data transfer per request
// over 1, 4 or 8 lanes with programmable SCK divider, latency and CE# recovery.
module psram_xfer_engine #(
  parameter int DATA_BYTES = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = $clog2(DATA_BYTES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [1:0]              cfg_pscr_i,
  input  logic [7:0]              cfg_recy_i,
  input  logic [7:0]              cfg_wlc_i,
  input  logic [7:0]              cfg_rlc_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_rdwr_i,
  input  logic [7:0]              req_cmd_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [LEN_WIDTH-1:0]    req_len_i,
  input  logic [DATA_BYTES*8-1:0] req_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_BYTES*8-1:0] rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  output logic                    psram_sck_o,
  output logic                    psram_ce_o,
  output logic [7:0]              psram_io_en_o,
  output logic [7:0]              psram_io_out_o,
  input  logic [7:0]              psram_io_in_i
);

  localparam int DW  = DATA_BYTES * 8;
  localparam int SHW = (ADDR_WIDTH > DW) ? ADDR_WIDTH : DW;
  localparam int CW  = 16;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WAIT, S_DATA, S_RESP, S_RECY} state_t;

  state_t                 state;
  logic [1:0]             mode_q, pscr_q, hcnt;
  logic [7:0]             recy_q, wait_q, rx_acc;
  logic                   rdwr_q;
  logic [LEN_WIDTH-1:0]   len_q, rx_idx;
  logic [SHW-1:0]         addr_sh_q, data_sh_q, sh;
  logic [CW-1:0]          pcnt;
  logic [3:0]             rx_bits;

  function automatic logic [3:0] lane_cnt(input logic [1:0] m);
    case (m)
      2'd0:    lane_cnt = 4'd1;
      2'd1:    lane_cnt = 4'd4;
      default: lane_cnt = 4'd8;
    endcase
  endfunction

  function automatic logic [1:0] lane_log(input logic [1:0] m);
    case (m)
      2'd0:    lane_log = 2'd0;
      2'd1:    lane_log = 2'd2;
      default: lane_log = 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask(input logic [1:0] m);
    case (m)
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

  // Shift registers are MSB-aligned; the top L bits are what goes on the lanes.
  function automatic logic [7:0] lane_bits(input logic [SHW-1:0] s, input logic [1:0] m);
    case (m)
      2'd0:    lane_bits = {7'b0, s[SHW-1]};
      2'd1:    lane_bits = {4'b0, s[SHW-1 -: 4]};
      default: lane_bits = s[SHW-1 -: 8];
    endcase
  endfunction

  logic            req_err;
  logic [DW-1:0]   wdata_rev;
  logic [SHW-1:0]  cmd_sh, sh_nx;
  logic [7:0]      rx_nx, dat_en, dat_out;
  logic [CW-1:0]   dat_cnt;

  always_comb begin
    req_err = (req_len_i == '0) || (32'(req_len_i) > 32'(DATA_BYTES));
    // Byte 0 goes first on the wire, so it lands in the top byte of the shifter.
    wdata_rev = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++)
      wdata_rev[(DATA_BYTES-1-i)*8 +: 8] = req_wdata_i[i*8 +: 8];
    cmd_sh  = SHW'(req_cmd_i) << (SHW - 8);
    sh_nx   = sh << lane_cnt(mode_q);
    case (mode_q)
      2'd0:    rx_nx = {rx_acc[6:0], psram_io_in_i[1]};
      2'd1:    rx_nx = {rx_acc[3:0], psram_io_in_i[3:0]};
      default: rx_nx = psram_io_in_i;
    endcase
    dat_en  = rdwr_q ? 8'h00 : lane_mask(mode_q);
    dat_out = rdwr_q ? 8'h00 : lane_bits(data_sh_q, mode_q);
    dat_cnt = (CW'(len_q) << 3) >> lane_log(mode_q);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      mode_q         <= '0;
      pscr_q         <= '0;
      hcnt           <= '0;
      recy_q         <= '0;
      wait_q         <= '0;
      rx_acc         <= '0;
      rdwr_q         <= 1'b0;
      len_q          <= '0;
      rx_idx         <= '0;
      addr_sh_q      <= '0;
      data_sh_q      <= '0;
      sh             <= '0;
      pcnt           <= '0;
      rx_bits        <= '0;
      req_ready_o    <= 1'b1;
      rsp_valid_o    <= 1'b0;
      rsp_rdata_o    <= '0;
      rsp_err_o      <= 1'b0;
      busy_o         <= 1'b0;
      psram_sck_o    <= 1'b0;
      psram_ce_o     <= 1'b1;
      psram_io_en_o  <= '0;
      psram_io_out_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid_i) begin
          mode_q      <= cfg_mode_i;
          pscr_q      <= cfg_pscr_i;
          recy_q      <= cfg_recy_i;
          wait_q      <= req_rdwr_i ? cfg_rlc_i : cfg_wlc_i;
          rdwr_q      <= req_rdwr_i;
          len_q       <= req_len_i;
          addr_sh_q   <= SHW'(req_addr_i) << (SHW - ADDR_WIDTH);
          data_sh_q   <= SHW'(wdata_rev) << (SHW - DW);
          req_ready_o <= 1'b0;
          busy_o      <= 1'b1;
          rsp_rdata_o <= '0;
          rsp_err_o   <= req_err;
          rx_bits     <= '0;
          rx_idx      <= '0;
          hcnt        <= '0;
          if (req_err) begin
            state       <= S_RESP;
            rsp_valid_o <= 1'b1;
          end else begin
            state          <= S_CMD;
            psram_ce_o     <= 1'b0;
            sh             <= cmd_sh;
            psram_io_en_o  <= lane_mask(cfg_mode_i);
            psram_io_out_o <= lane_bits(cmd_sh, cfg_mode_i);
            pcnt           <= CW'(8) >> lane_log(cfg_mode_i);
          end
        end
        S_CMD, S_ADDR, S_WAIT, S_DATA: begin
          if (hcnt != pscr_q) begin
            hcnt <= hcnt + 1'b1;
          end else begin
            hcnt <= '0;
            if (!psram_sck_o) begin
              psram_sck_o <= 1'b1;
              if (state == S_DATA && rdwr_q) begin
                rx_acc <= rx_nx;
                if (rx_bits + lane_cnt(mode_q) == 4'd8) begin
                  rsp_rdata_o[rx_idx*8 +: 8] <= rx_nx;
                  rx_bits <= '0;
                  rx_idx  <= rx_idx + 1'b1;
                end else begin
                  rx_bits <= rx_bits + lane_cnt(mode_q);
                end
              end
            end else begin
              psram_sck_o <= 1'b0;
              if (pcnt != CW'(1)) begin
                pcnt           <= pcnt - 1'b1;
                sh             <= sh_nx;
                psram_io_out_o <= (psram_io_en_o != 8'h00) ? lane_bits(sh_nx, mode_q) : 8'h00;
              end else begin
                case (state)
                  S_CMD: begin
                    state          <= S_ADDR;
                    sh             <= addr_sh_q;
                    psram_io_out_o <= lane_bits(addr_sh_q, mode_q);
                    pcnt           <= CW'(ADDR_WIDTH) >> lane_log(mode_q);
                  end
                  S_DATA: begin
                    state          <= S_RESP;
                    psram_ce_o     <= 1'b1;
                    psram_io_en_o  <= '0;
                    psram_io_out_o <= '0;
                    rsp_valid_o    <= 1'b1;
                  end
                  default: begin
                    if (state == S_ADDR && wait_q != 8'd0) begin
                      state          <= S_WAIT;
                      psram_io_en_o  <= '0;
                      psram_io_out_o <= '0;
                      pcnt           <= CW'(wait_q);
                    end else begin
                      state          <= S_DATA;
                      sh             <= data_sh_q;
                      psram_io_en_o  <= dat_en;
                      psram_io_out_o <= dat_out;
                      pcnt           <= dat_cnt;
                    end
                  end
                endcase
              end
            end
          end
        end
        S_RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          if (recy_q != 8'd0) begin
            state <= S_RECY;
            pcnt  <= CW'(recy_q);
          end else begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        S_RECY: begin
          if (pcnt == CW'(1)) begin
            state       <= S_IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_xfer_engine.sv
// Directed bench for psram_xfer_engine with a response scoreboard and pad-side capture.
module tb_psram_xfer_engine;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  cfg_mode_i, cfg_pscr_i;
  logic [7:0]  cfg_recy_i, cfg_wlc_i, cfg_rlc_i;
  logic        req_valid_i, req_ready_o, req_rdwr_i;
  logic [7:0]  req_cmd_i;
  logic [31:0] req_addr_i;
  logic [3:0]  req_len_i;
  logic [63:0] req_wdata_i, rsp_rdata_o;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  logic        psram_sck_o, psram_ce_o;
  logic [7:0]  psram_io_en_o, psram_io_out_o, psram_io_in_i;

  psram_xfer_engine #(.DATA_BYTES(8), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cfg_mode_i(cfg_mode_i), .cfg_pscr_i(cfg_pscr_i), .cfg_recy_i(cfg_recy_i),
    .cfg_wlc_i(cfg_wlc_i), .cfg_rlc_i(cfg_rlc_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rdwr_i(req_rdwr_i),
    .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o),
    .psram_sck_o(psram_sck_o), .psram_ce_o(psram_ce_o), .psram_io_en_o(psram_io_en_o),
    .psram_io_out_o(psram_io_out_o), .psram_io_in_i(psram_io_in_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int unsigned cyc;
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] cap_q[$];
  int          ce_falls = 0;
  int          fall_cnt = 0;
  int          pre_falls = 0;
  logic [7:0]  pad [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Lane state as seen by the device on each SCK rising edge.
  always @(posedge psram_sck_o) cap_q.push_back({psram_io_en_o, psram_io_out_o});
  always @(negedge psram_ce_o) ce_falls++;

  // Pad model: presents pad[k] for the k-th data period, changing on SCK fall.
  initial begin
    psram_io_in_i = 8'h00;
    forever begin
      @(negedge psram_sck_o);
      fall_cnt++;
      if (fall_cnt >= pre_falls && fall_cnt - pre_falls < 8)
        psram_io_in_i = pad[fall_cnt - pre_falls];
      else
        psram_io_in_i = 8'h00;
    end
  end

  // Response monitor: pops expectation on first valid cycle, checks stability while held.
  initial begin
    exp_t cur;
    bit   active = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i || !rsp_valid_o) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rsp: actual=rsp_valid required=none (t=%0t)", $time);
          end else begin
            cur = exp_q.pop_front();
            active = 1'b1;
            check("rsp_cycle", 64'(cyc), 64'(cur.cyc));
          end
        end
        if (active) begin
          check("rsp_rdata", rsp_rdata_o, cur.rdata);
          check("rsp_err", 64'(rsp_err_o), 64'(cur.err));
        end
      end
    end
  end

  task automatic issue(input bit rd, input logic [7:0] cmd, input logic [31:0] addr,
                       input logic [3:0] len, input logic [63:0] wd, input logic [1:0] mode,
                       input logic [1:0] pscr, input logic [7:0] wlc, input logic [7:0] rlc,
                       input logic [7:0] recy, input bit push, input int unsigned lat,
                       input logic [63:0] exp_rd, input bit exp_err);
    int n = 0;
    @(negedge clk_i);
    while (!req_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 300) check("req_ready_timeout", 64'(req_ready_o), 64'd1);
    cap_q.delete();
    fall_cnt   = 0;
    req_rdwr_i = rd;  req_cmd_i = cmd;  req_addr_i = addr;  req_len_i = len;
    req_wdata_i = wd; cfg_mode_i = mode; cfg_pscr_i = pscr; cfg_wlc_i = wlc;
    cfg_rlc_i = rlc;  cfg_recy_i = recy;
    req_valid_i = 1'b1;
    if (push) exp_q.push_back('{cyc + 1 + lat, exp_rd, exp_err});
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || rsp_valid_o || !req_ready_o) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 2000) check("rsp_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [47:0] sbits;
    logic [63:0] nib;
    logic [7:0]  en_and, en_or;
    int          ce0;

    rst_n_i = 1'b0; rsp_ready_i = 1'b1; req_valid_i = 1'b0; req_rdwr_i = 1'b0;
    req_cmd_i = '0; req_addr_i = '0; req_len_i = '0; req_wdata_i = '0;
    cfg_mode_i = '0; cfg_pscr_i = '0; cfg_recy_i = '0; cfg_wlc_i = '0; cfg_rlc_i = '0;
    pad = '{8'hC1, 8'h72, 8'h3E, 8'h09, 8'hF4, 8'h5B, 8'hA6, 8'h8D};
    repeat (3) @(negedge clk_i);
    check("reset_outputs",
          {psram_ce_o, psram_sck_o, psram_io_en_o, psram_io_out_o, req_ready_o, rsp_valid_o, rsp_err_o, busy_o},
          {1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    check("reset_rdata", rsp_rdata_o, 64'd0);
    rst_n_i = 1'b1;

    // SPI write, 1 byte: 8+32+8 = 48 SCK at 2 clk each
    issue(1'b0, 8'h02, 32'h0000_1234, 4'd1, 64'h0000_0000_0000_005A, 2'd0, 2'd0, 8'd0, 8'd4,
          8'd0, 1'b1, 96, 64'd0, 1'b0);
    wait_done();
    check("spi_sck_count", 64'(cap_q.size()), 64'd48);
    sbits = '0; en_and = 8'hFF; en_or = 8'h00;
    foreach (cap_q[i]) begin
      sbits = {sbits[46:0], cap_q[i][0]};
      en_and &= cap_q[i][15:8];
      en_or  |= cap_q[i][15:8];
    end
    check("spi_bitstream", 64'(sbits), 64'h0000_0200_0012_345A);
    check("spi_io_en", {en_and, en_or}, {8'h01, 8'h01});

    // OPI read, 8 bytes, pscr=1, rlc=6: 1+4+6+8 = 19 SCK at 4 clk each
    pre_falls = 11;
    issue(1'b1, 8'hEB, 32'h0000_ABCD, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 2'd1, 8'd2, 8'd6,
          8'd0, 1'b1, 76, 64'h8DA6_5BF4_093E_72C1, 1'b0);
    wait_done();
    check("opi_sck_count", 64'(cap_q.size()), 64'd19);
    if (cap_q.size() == 19) begin
      check("opi_cmd_lanes", 64'(cap_q[0]), 64'hFFEB);
      check("opi_addr_last", 64'(cap_q[4]), 64'hFFCD);
      check("opi_wait_en", 64'(cap_q[5]), 64'h0000);
      check("opi_rdata_en", 64'(cap_q[18]), 64'h0000);
    end

    // QPI write, 3 bytes, wlc=2: 2+8+2+6 = 18 SCK
    issue(1'b0, 8'h38, 32'h89AB_CDEF, 4'd3, 64'h0000_0000_00C3_B2A1, 2'd1, 2'd0, 8'd2, 8'd5,
          8'd0, 1'b1, 36, 64'd0, 1'b0);
    wait_done();
    check("qpi_sck_count", 64'(cap_q.size()), 64'd18);
    nib = '0; en_or = 8'h00;
    foreach (cap_q[i]) begin
      if (cap_q[i][15:8] != 8'h00) begin
        nib = {nib[59:0], cap_q[i][3:0]};
        en_or |= cap_q[i][15:8];
      end
    end
    check("qpi_nibbles", nib, 64'h3889_ABCD_EFA1_B2C3);
    check("qpi_io_en", 64'(en_or), 64'h0F);
    if (cap_q.size() == 18) check("qpi_wait_slot", 64'(cap_q[10]), 64'h0000);

    // Illegal lengths: immediate error response, no CE#/SCK activity
    ce0 = ce_falls;
    issue(1'b1, 8'hEB, 32'h1, 4'd0, 64'h1234, 2'd2, 2'd0, 8'd3, 8'd3, 8'd0, 1'b1, 0, 64'd0, 1'b1);
    wait_done();
    issue(1'b0, 8'h02, 32'h1, 4'd9, 64'h1234, 2'd0, 2'd0, 8'd3, 8'd3, 8'd0, 1'b1, 0, 64'd0, 1'b1);
    wait_done();
    check("err_no_ce", 64'(ce_falls - ce0), 64'd0);
    check("err_no_sck", 64'(cap_q.size()), 64'd0);

    // Response backpressure for 5 clks, then 3 clks of recovery
    rsp_ready_i = 1'b0;
    issue(1'b0, 8'h02, 32'h1, 4'd9, 64'h0, 2'd0, 2'd0, 8'd0, 8'd0, 8'd3, 1'b1, 0, 64'd0, 1'b1);
    repeat (4) @(negedge clk_i);
    check("held_valid", 64'(rsp_valid_o), 64'd1);
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check("recy_req_ready", 64'(req_ready_o), (k == 3) ? 64'd1 : 64'd0);
    end
    check("recy_rsp_dropped", 64'(rsp_valid_o), 64'd0);

    // Reset during the read data phase aborts with no response
    issue(1'b1, 8'hEB, 32'h0, 4'd8, 64'h0, 2'd2, 2'd1, 8'd0, 8'd0, 8'd0, 1'b0, 0, 64'd0, 1'b0);
    repeat (23) @(negedge clk_i);
    check("mid_data_active", {63'd0, psram_ce_o}, 64'd0);
    #2 rst_n_i = 1'b0;
    #1;
    check("abort_pins", {psram_ce_o, psram_sck_o, psram_io_en_o}, {1'b1, 1'b0, 8'h00});
    check("abort_status", {req_ready_o, rsp_valid_o, busy_o}, {1'b1, 1'b0, 1'b0});
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (120) @(negedge clk_i);

    // Recovery after abort: OPI write 1 byte, 1+4+1 = 6 SCK
    issue(1'b0, 8'h02, 32'h0000_0010, 4'd1, 64'h77, 2'd2, 2'd0, 8'd0, 8'd0, 8'd0, 1'b1, 12,
          64'd0, 1'b0);
    wait_done();
    check("post_reset_sck_count", 64'(cap_q.size()), 64'd6);
    check("pending_rsp", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
